// File: rtl/lr35902_pkg.sv
// Shared definitions for the LR35902 interrupt controller: source indices,
// source count, vector base and dispatch FSM encoding.
package lr35902_pkg;

  localparam int NUM_IRQ = 5;
  localparam int IDX_W   = $clog2(NUM_IRQ);
  localparam logic [7:0] VEC_BASE = 8'h40;

  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_DISPATCH = 1'b1
  } irq_state_t;

  // Source n lives 8 bytes above source n-1.
  function automatic logic [7:0] irq_vector(input logic [IDX_W-1:0] idx);
    return VEC_BASE + 8'({idx, 3'b000});
  endfunction

endpackage

// File: rtl/lr35902_irqctl_if.sv
// CPU-side register bus and dispatch handshake of the interrupt controller.
interface lr35902_irqctl_if;

  logic       cs_if;
  logic       cs_ie;
  logic       write;
  logic [7:0] din;
  logic [7:0] dout;
  logic       int_pending;
  logic       int_start;
  logic       int_ack;
  logic [7:0] int_vec;
  logic       int_busy;

  modport master (
    output cs_if, cs_ie, write, din, int_start, int_ack,
    input  dout, int_pending, int_vec, int_busy
  );

  modport slave (
    input  cs_if, cs_ie, write, din, int_start, int_ack,
    output dout, int_pending, int_vec, int_busy
  );

endinterface

// File: rtl/lr35902_irq_prio.sv
// Fixed-priority encoder: lowest set request bit wins.
module lr35902_irq_prio
  import lr35902_pkg::*;
(
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  // Scan downward so the lowest active index is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/lr35902_irqctl.sv
// LR35902 interrupt controller: IF/IE registers, fixed-priority arbitration
// and the dispatch handshake with the CPU core.
module lr35902_irqctl
  import lr35902_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  lr35902_irqctl_if.slave    bus
);

  logic [NUM_IRQ-1:0] if_q;
  logic [NUM_IRQ-1:0] if_base;
  logic [NUM_IRQ-1:0] if_d;
  logic [NUM_IRQ-1:0] ack_clear;
  logic [7:0]         ie_q;
  irq_state_t         state_q;
  logic               busy_q;
  logic               sel_valid;
  logic [IDX_W-1:0]   sel_idx;

  lr35902_irq_prio u_prio (
    .req   (if_q & ie_q[NUM_IRQ-1:0]),
    .valid (sel_valid),
    .idx   (sel_idx)
  );

  always_comb begin
    if (bus.cs_if)      bus.dout = {{(8 - NUM_IRQ){1'b1}}, if_q};
    else if (bus.cs_ie) bus.dout = ie_q;
    else                bus.dout = 8'hFF;
  end

  assign bus.int_pending = sel_valid;
  assign bus.int_busy    = busy_q;
  // Re-evaluated every cycle so an IE/IF write mid-dispatch collapses the vector to 0.
  assign bus.int_vec     = (busy_q && sel_valid) ? irq_vector(sel_idx) : 8'h00;

  always_comb begin
    ack_clear = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      ack_clear[i] = (state_q == ST_DISPATCH) && bus.int_ack && sel_valid &&
                     (sel_idx == IDX_W'(i));
    end
  end

  // A peripheral pulse overrides both the CPU write and the ack clear.
  assign if_base = (bus.write && bus.cs_if) ? bus.din[NUM_IRQ-1:0] : if_q;
  assign if_d    = (if_base & ~ack_clear) | irq_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      if_q    <= '0;
      ie_q    <= 8'h00;
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
    end else begin
      if_q <= if_d;
      if (bus.write && bus.cs_ie) ie_q <= bus.din;
      case (state_q)
        ST_IDLE: begin
          if (bus.int_start) begin
            state_q <= ST_DISPATCH;
            busy_q  <= 1'b1;
          end
        end
        ST_DISPATCH: begin
          if (bus.int_ack) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/lr35902_irqctl.md
Name: lr35902_irqctl

Overview:
Interrupt controller for the LR35902 core.
- Owns the IF register (0xFF0F) and the IE register (0xFFFF), both selected through the I/O map's cs_if/cs_ie strobes.
- Collects single-cycle request pulses from the joypad, link port, timer and PPU.
- Arbitrates them by fixed priority and runs the dispatch handshake with the CPU core, supplying the vector and clearing the serviced flag.

Parameters:
NUM_IRQ, 5, number of interrupt sources; bit 0 is the highest priority.
VEC_BASE, 8'h40, vector of source 0; source n vectors to VEC_BASE + 8*n.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cs_if  in  1  IF register select, from the I/O map
cs_ie  in  1  IE register select, from the I/O map
write  in  1  CPU write strobe, qualified by cs_*
din  in  8  CPU write data
dout  out  8  CPU read data, combinational
irq_in  in  NUM_IRQ  request pulses; bit0 VBlank, bit1 STAT, bit2 timer, bit3 serial, bit4 joypad
int_pending  out  1  |(IF & IE[NUM_IRQ-1:0]); used for HALT/STOP wake, independent of IME
int_start  in  1  core begins interrupt dispatch (IME already checked by core)
int_ack  in  1  core has taken the vector; one cycle, only valid in DISPATCH
int_vec  out  8  vector of the dispatch in progress
int_busy  out  1  high while in DISPATCH

Behaviour:
Reset:
- IF = 0, IE = 8'h00, state = IDLE.
- Outputs: int_pending = 0, int_busy = 0, int_vec = 8'h00.
- Reset mid-dispatch aborts silently; no flag is cleared.

Registers and CPU access:
- IF is NUM_IRQ bits. A read with cs_if gives {3'b111, IF}.
- IE is a full 8 bits. A read with cs_ie gives IE.
- With neither select active, dout = 8'hFF.
- A write with cs_if loads IF <= din[NUM_IRQ-1:0].
- A write with cs_ie loads IE <= din.
- Writes take effect at the clock edge, so int_pending reflects the write on the following cycle.

IF next-state, per bit i, evaluated in this order:
- base = write&cs_if ? din[i] : IF[i]
- if ack_clear[i]: base = 0
- IF'[i] = base | irq_in[i]
- So a peripheral set always wins over both a CPU write and an ack clear in the same cycle.
- ack_clear is one-hot or zero (see DISPATCH).

Priority select:
- sel = lowest index i with IF[i] & IE[i]. none = no such bit.

FSM states:
- IDLE
  - int_busy = 0, int_vec = 8'h00.
  - int_start -> DISPATCH, regardless of int_pending.
  - int_ack in IDLE is ignored and clears nothing.
- DISPATCH
  - int_busy = 1.
  - int_vec is combinational and re-evaluated every cycle: VEC_BASE + 8*sel, or 8'h00 if none. This deliberately models the hardware quirk where an IE/IF write during the push cancels dispatch to 0x0000.
  - int_ack: ack_clear = onehot(sel), or 0 if none; -> IDLE.
  - int_start while already in DISPATCH is ignored.
- No timeout: the core guarantees an ack within 5 machine cycles.

Simultaneous int_ack and IE write:
- sel uses current register values, before the write.

Upper IE bits:
- IE[7:NUM_IRQ] are stored and read back but never participate in sel or int_pending.

Decomposition:
- Shared package (lr35902_pkg): IRQ bit indices (IRQ_VBLANK=0 .. IRQ_JOYPAD=4), NUM_IRQ, VEC_BASE, FSM state encoding.
- One sub-module is natural: lr35902_irq_prio, a combinational priority encoder taking IF&IE and producing {valid, index}. All state stays in lr35902_irqctl.

Test Plan:
- Reset: after reset, read IF -> 8'hE0, read IE -> 8'h00, int_pending = 0, int_busy = 0.
- Priority: IE=8'h1F; pulse irq_in bits 2 and 0 in the same cycle; int_start -> int_vec = 8'h40; int_ack -> IF = 5'b00100; second dispatch -> int_vec = 8'h50; ack -> IF = 0.
- Masking: IE=8'h04, IF written 8'h1B -> int_pending = 0; pulse timer -> int_pending = 1 the next cycle; IE reads back 8'h04 and IF reads back 8'hFF.
- Cancel quirk: IE=8'h01, IF=01, int_start; write IE=8'h00 during DISPATCH -> int_vec = 8'h00; int_ack -> IF unchanged at 5'b00001, state returns to IDLE.
- Collision: in DISPATCH serving VBlank, the int_ack cycle coincides with irq_in[0] and a write IF=8'h00 -> IF[0] = 1 afterwards (set wins).
- Spurious handshake: int_ack in IDLE -> no IF change; reset asserted during DISPATCH -> IDLE, IF = 0 on the next cycle.
